// File: rtl/rca_4bit.sv
// Registered WIDTH-bit ripple-carry adder: {o_cy, o_s} = i_a + i_b + i_cin, one cycle latency.
// Optional macro RCA_4BIT_OVF_EN adds o_ovf (registered signed overflow) and o_cy_comb (unregistered carry-out).
module rca_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cy,
  output logic             o_vld
`ifdef RCA_4BIT_OVF_EN
  ,
  output logic             o_ovf,
  output logic             o_cy_comb
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic             cy_d;
  logic [WIDTH-1:0] s_q;
  logic             cy_q;
  logic             vld_q;

  assign c[0] = i_cin;

  // Full-adder cells; carry ripples from bit 0 upward with no lookahead.
  for (genvar k = 0; k < WIDTH; k++) begin : g_fa
    assign s_d[k]   = i_a[k] ^ i_b[k] ^ c[k];
    assign c[k+1]   = (i_a[k] & i_b[k]) | (i_a[k] & c[k]) | (i_b[k] & c[k]);
  end

  assign cy_d = c[WIDTH];

  // Stage boundary: result register, loads only on valid input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q   <= '0;
      cy_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= i_vld;
      if (i_vld) begin
        s_q  <= s_d;
        cy_q <= cy_d;
      end
    end
  end

  assign o_s   = s_q;
  assign o_cy  = cy_q;
  assign o_vld = vld_q;

`ifdef RCA_4BIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (i_vld) begin
      ovf_q <= ovf_d;
    end
  end

  assign o_ovf     = ovf_q;
  assign o_cy_comb = cy_d;
`endif

endmodule

// File: tb/tb_rca_4bit.sv
// Scoreboard bench for rca_4bit: stimulus pushes expected results, a negedge monitor pops on o_vld.
module tb_rca_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         vld;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cy;
  logic         ovld;
`ifdef RCA_4BIT_OVF_EN
  logic         ovf;
  logic         cy_comb;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         cy;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rca_4bit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (vld),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_s     (s),
    .o_cy    (cy),
    .o_vld   (ovld)
`ifdef RCA_4BIT_OVF_EN
    ,
    .o_ovf     (ovf),
    .o_cy_comb (cy_comb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: exact integer sum plus signed-range overflow test.
  function automatic exp_t model(input int ai, input int bi, input int ci);
    exp_t e;
    int   sum;
    int   sa;
    int   sb;
    int   ssum;
    sum  = ai + bi + ci;
    sa   = (ai >= 8) ? ai - 16 : ai;
    sb   = (bi >= 8) ? bi - 16 : bi;
    ssum = sa + sb + ci;
    e.s   = sum[W-1:0];
    e.cy  = (sum >= 16);
    e.ovf = (ssum > 7) || (ssum < -8);
    return e;
  endfunction

  task automatic issue(input int ai, input int bi, input int ci, input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    a   = ai[W-1:0];
    b   = bi[W-1:0];
    cin = ci[0];
    vld = v;
    if (v) begin
      e = model(ai, bi, ci);
      exp_q.push_back(e);
`ifdef RCA_4BIT_OVF_EN
      #1;
      chk("cy_comb", int'(cy_comb), int'(e.cy));
`endif
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ovld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got o_s=%0d with no pending expectation at %0t", s, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sum", int'(s), int'(e.s));
        chk("carry", int'(cy), int'(e.cy));
`ifdef RCA_4BIT_OVF_EN
        chk("ovf", int'(ovf), int'(e.ovf));
`endif
      end
    end
  end

  int dir_tab[12][3] = '{
    '{0, 0, 0}, '{1, 1, 1}, '{3, 3, 1}, '{5, 5, 0}, '{7, 7, 0},
    '{8, 8, 1}, '{9, 9, 1}, '{12, 12, 1}, '{14, 14, 1}, '{15, 15, 0},
    '{15, 0, 1}, '{15, 15, 1}
  };
  // Hand-computed {sum, carry} for dir_tab rows.
  int dir_exp[12][2] = '{
    '{0, 0}, '{3, 0}, '{7, 0}, '{10, 0}, '{14, 0},
    '{1, 1}, '{3, 1}, '{9, 1}, '{13, 1}, '{14, 1},
    '{0, 1}, '{15, 1}
  };

  initial begin
    rst_n = 1'b0;
    vld   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    #3;
    chk("reset_s", int'(s), 0);
    chk("reset_cy", int'(cy), 0);
    chk("reset_vld", int'(ovld), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cross-check the hand table against the model before use.
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      e = model(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2]);
      if (int'(e.s) != dir_exp[i][0] || int'(e.cy) != dir_exp[i][1])
        $display("Note: table row %0d disagrees with model", i);
    end

    for (int i = 0; i < 12; i++) begin
      exp_t e;
      issue(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], 1'b1);
      e.s   = dir_exp[i][0][W-1:0];
      e.cy  = dir_exp[i][1][0];
      e.ovf = model(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2]).ovf;
      exp_q[exp_q.size()-1] = e;
    end

    // Hold: valid 3+3+1 then invalid 15+15+0.
    issue(3, 3, 1, 1'b1);
    issue(15, 15, 0, 1'b0);
    @(posedge clk);
    #2;
    chk("hold_vld", int'(ovld), 0);
    chk("hold_s", int'(s), 7);
    chk("hold_cy", int'(cy), 0);

    // Asynchronous reset mid-cycle while o_s = 0111.
    @(negedge clk);
    #2;
    chk("pre_reset_s", int'(s), 7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_s", int'(s), 0);
    chk("async_rst_cy", int'(cy), 0);
    chk("async_rst_vld", int'(ovld), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RCA_4BIT_OVF_EN
    issue(7, 1, 0, 1'b1);
    issue(8, 8, 0, 1'b1);
    issue(3, 3, 1, 1'b1);
`endif

    // Exhaustive back-to-back sweep.
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          issue(ai, bi, ci, 1'b1);

    issue(0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_4bit.md
Name: rca_4bit

Overview:
- Registered 4-bit ripple-carry adder: computes A + B + carry-in through a chain of single-bit full adders.
- Captures sum and carry-out on the clock edge.
- Leaf arithmetic block; four instances chain carry-out to carry-in to form a 16-bit adder.
- Carry-in of the lowest slice comes from the system; carry-out of the top slice is the wide adder's carry-out.

Parameters:
- WIDTH, 4, operand/sum width in bits. The 16-bit composition requires 4; must be ≥ 1.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_vld  input  1  operands/carry-in valid this cycle
- i_a  input  WIDTH  operand A, unsigned
- i_b  input  WIDTH  operand B, unsigned
- i_cin  input  1  carry-in
- o_s  output  WIDTH  registered sum
- o_cy  output  1  registered carry-out
- o_vld  output  1  o_s/o_cy updated by a valid input last cycle

Behaviour:
- Datapath structure:
  - WIDTH full-adder cells in a ripple chain.
  - Bit k: s_k = a_k ^ b_k ^ c_k; c_{k+1} = a_k&b_k | a_k&c_k | b_k&c_k.
  - c_0 = i_cin; carry-out = c_WIDTH.
  - No carry-lookahead.
- Arithmetic: {o_cy, o_s} = i_a + i_b + i_cin, exact, WIDTH+1 bits; no truncation, no saturation.
- Register stage:
  - On a rising i_clk with i_vld=1: o_s and o_cy load the combinational result; o_vld <= 1.
  - On a rising i_clk with i_vld=0: o_s and o_cy hold their previous value; o_vld <= 0.
- Latency: exactly 1 cycle from valid input to o_vld=1 with the result. Back-to-back valid inputs are accepted every cycle. No backpressure.
- Reset:
  - While i_rst_n=0: o_s=0, o_cy=0, o_vld=0 immediately, independent of i_clk.
  - An operation in flight when reset asserts is discarded.
  - First capture happens on the first rising edge after i_rst_n deasserts.
- X handling: no requirement when i_vld=0; inputs are don't-care in that case.
- Boundary cases:
  - Max: 15+15+1 = 31 → o_s=1111, o_cy=1.
  - Min: 0+0+0 → o_s=0000, o_cy=0.
  - Carry ripples through all bits: 1111+0000+1 → o_s=0000, o_cy=1.
- Chaining: the carry-out is registered, so cascaded slices meet the 1-cycle latency only when fed combinationally. For the 16-bit composition, the integrator uses the combinational carry (see Optional Feature) or accepts per-slice skew.

Optional Feature:
- Macro: RCA_4BIT_OVF_EN.
- When defined:
  - Adds output port o_ovf (1 bit): registered signed two's-complement overflow, c_WIDTH ^ c_{WIDTH-1}.
  - o_ovf updates under the same i_vld rule as o_s and resets to 0.
  - Adds output port o_cy_comb (1 bit): unregistered combinational carry-out, for zero-skew cascading.
- When undefined: neither port exists; the interface is exactly as listed above.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle with o_s=0111 → o_s, o_cy and o_vld go to 0 immediately, before the next clock edge.
- Directed vectors, each with i_vld=1, result checked one cycle later with o_vld=1:
  - 0+0+0 → s=0000, cy=0
  - 1+1+1 → s=0011, cy=0
  - 3+3+1 → s=0111, cy=0
  - 5+5+0 → s=1010, cy=0
  - 7+7+0 → s=1110, cy=0
- Carry-out vectors:
  - 8+8+1 → s=0001, cy=1
  - 9+9+1 → s=0011, cy=1
  - 12+12+1 → s=1001, cy=1
  - 14+14+1 → s=1101, cy=1
  - 15+15+0 → s=1110, cy=1
- Full ripple: 1111+0000+1 → s=0000, cy=1; 15+15+1 → s=1111, cy=1.
- Hold: apply 3+3+1 with i_vld=1, then change to 15+15+0 with i_vld=0 → o_s stays 0111, o_vld drops to 0. Also run an exhaustive 512-case sweep against a reference model, one per cycle, back-to-back.
- Optional feature (RCA_4BIT_OVF_EN): 7+1+0 → o_ovf=1; 8+8+0 → o_ovf=1, o_cy=1; 3+3+1 → o_ovf=0. Check o_cy_comb matches the next-cycle o_cy.
